// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode definitions: NOP encoding, exception codes and the
// default entry field widths used by the IF/ID queue.
package cpu_defs;

  localparam int          INSTR_W  = 32;
  localparam int          EXC_W    = 5;
  localparam logic [31:0] NOP      = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;

endpackage

// File: rtl/if_id_queue_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the IF/ID queue. The storage array lives
// in the parent; this block only decides when and where to write and read.
module fifo_ctrl
  import cpu_defs::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          wr_en,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // full/empty come only from the registered count, so there is no
  // combinational path from decode's ready back to fetch's ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = push_req & ~full;
  assign pop   = pop_req & ~empty;
  assign wr_en = push & ~flush & ~reset;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry decoupling queue between fetch and decode. Presents a NOP
// bubble (all-zero fields) to decode whenever the queue is empty.
module if_id_queue
  import cpu_defs::*;
#(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  parameter int  EXC_W = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [WIDTH-1:0] INSTR,
  input  logic [WIDTH-1:0] PC4,
  input  logic [EXC_W-1:0] f_exc,
  input  logic             f_bd,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] IR_D,
  output logic [WIDTH-1:0] PC4_D,
  output logic [EXC_W-1:0] EXC_D,
  output logic             BD_D,
  output logic [CW-1:0]    count
);

  logic          wr_en, full, empty;
  logic [PW-1:0] rd_ptr, wr_ptr;

  fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push_req (f_valid),
    .pop_req  (d_ready),
    .wr_en    (wr_en),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign f_ready = ~full;
  assign d_valid = ~empty;

  // Storage is deliberately unreset; stale contents are masked by d_valid.
  logic [WIDTH-1:0] ir_mem  [DEPTH];
  logic [WIDTH-1:0] pc4_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem [DEPTH];
  logic             bd_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ir_mem[wr_ptr]  <= INSTR;
      pc4_mem[wr_ptr] <= PC4;
      exc_mem[wr_ptr] <= f_exc;
      bd_mem[wr_ptr]  <= f_bd;
    end
  end

  assign IR_D  = d_valid ? ir_mem[rd_ptr]  : WIDTH'(NOP);
  assign PC4_D = d_valid ? pc4_mem[rd_ptr] : '0;
  assign EXC_D = d_valid ? exc_mem[rd_ptr] : EXC_W'(EXC_NONE);
  assign BD_D  = d_valid & bd_mem[rd_ptr];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_if_id_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int EXC_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 0;
  logic             reset = 0, flush = 0, f_valid = 0, d_ready = 0, f_bd = 0;
  logic [WIDTH-1:0] INSTR = '0, PC4 = '0;
  logic [EXC_W-1:0] f_exc = '0;
  logic             f_ready, d_valid, BD_D;
  logic [WIDTH-1:0] IR_D, PC4_D;
  logic [EXC_W-1:0] EXC_D;
  logic [CW-1:0]    count;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  if_id_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready),
    .INSTR(INSTR), .PC4(PC4), .f_exc(f_exc), .f_bd(f_bd),
    .d_valid(d_valid), .d_ready(d_ready),
    .IR_D(IR_D), .PC4_D(PC4_D), .EXC_D(EXC_D), .BD_D(BD_D),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] pc4;
    logic [EXC_W-1:0] exc;
    logic             bd;
  } ent_t;

  ent_t mq[$];

  // Reference model: an unbounded queue capped at DEPTH by the accept rule.
  always @(posedge clk) begin
    bit can_push, can_pop;
    ent_t e;
    if (reset || flush) mq.delete();
    else begin
      can_push = f_valid && (mq.size() < DEPTH);
      can_pop  = d_ready && (mq.size() > 0);
      e.ir = INSTR; e.pc4 = PC4; e.exc = f_exc; e.bd = f_bd;
      if (can_pop)  void'(mq.pop_front());
      if (can_push) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [WIDTH-1:0] e_ir, e_pc4;
      logic [EXC_W-1:0] e_exc;
      logic             e_bd, e_dv, e_fr;
      logic [CW-1:0]    e_cnt;
      e_dv  = mq.size() > 0;
      e_fr  = mq.size() < DEPTH;
      e_cnt = CW'(mq.size());
      e_ir  = e_dv ? mq[0].ir  : '0;
      e_pc4 = e_dv ? mq[0].pc4 : '0;
      e_exc = e_dv ? mq[0].exc : '0;
      e_bd  = e_dv ? mq[0].bd  : 1'b0;
      checks++;
      if ({d_valid, f_ready, count, IR_D, PC4_D, EXC_D, BD_D} !==
          {e_dv, e_fr, e_cnt, e_ir, e_pc4, e_exc, e_bd}) begin
        failures++;
        $display("FAIL model t=%0t got dv=%b fr=%b cnt=%0d ir=%h pc4=%h exc=%0d bd=%b want dv=%b fr=%b cnt=%0d ir=%h pc4=%h exc=%0d bd=%b",
                 $time, d_valid, f_ready, count, IR_D, PC4_D, EXC_D, BD_D,
                 e_dv, e_fr, e_cnt, e_ir, e_pc4, e_exc, e_bd);
      end
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Advance past one rising edge; outputs are settled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ir, input logic [31:0] pc4);
    f_valid = v; INSTR = ir; PC4 = pc4;
  endtask

  initial begin
    // Reset then idle
    #2;
    reset = 1; f_valid = 1; INSTR = 32'hdead_beef; PC4 = 32'h1111_1111;
    tick();
    reset = 0; f_valid = 0;
    chk_en = 1;
    lit("rst_dvalid", 64'(d_valid), 64'd0);
    lit("rst_fready", 64'(f_ready), 64'd1);
    lit("rst_ir",     64'(IR_D),    64'd0);
    lit("rst_pc4",    64'(PC4_D),   64'd0);
    lit("rst_count",  64'(count),   64'd0);
    tick();

    // Single pass
    set_in(1, 32'h2408_0005, 32'h0000_3004);
    tick();
    f_valid = 0;
    lit("sp_dvalid", 64'(d_valid), 64'd1);
    lit("sp_ir",     64'(IR_D),    64'h2408_0005);
    lit("sp_pc4",    64'(PC4_D),   64'h0000_3004);
    lit("sp_count",  64'(count),   64'd1);
    tick();
    lit("sp_stall_ir", 64'(IR_D), 64'h2408_0005);
    d_ready = 1;
    tick();
    d_ready = 0;
    lit("sp_pop_dvalid", 64'(d_valid), 64'd0);
    lit("sp_pop_ir",     64'(IR_D),    64'd0);

    // Fill to full, then a dropped fifth push
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h0000_0100 + 32'(i), 32'h0000_3004 + 32'(4 * i));
      tick();
    end
    lit("full_count",  64'(count),   64'd4);
    lit("full_fready", 64'(f_ready), 64'd0);
    set_in(1, 32'h0000_0104, 32'h0000_3014);
    tick();
    f_valid = 0;
    lit("full_drop_count", 64'(count), 64'd4);
    d_ready = 1;
    for (int i = 0; i < 4; i++) begin
      lit("drain_pc4", 64'(PC4_D), 64'h3004 + 64'(4 * i));
      tick();
    end
    d_ready = 0;
    lit("drain_empty", 64'(d_valid), 64'd0);
    lit("drain_pc4_0", 64'(PC4_D),   64'd0);

    // Simultaneous push/pop at count = 2 across 3*DEPTH transfers
    for (int n = 0; n < 2; n++) begin
      set_in(1, 32'h0000_0200 + 32'(n), 32'h0000_4000 + 32'(4 * n));
      tick();
    end
    d_ready = 1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      set_in(1, 32'h0000_0200 + 32'(k + 2), 32'h0000_4000 + 32'(4 * (k + 2)));
      tick();
      lit("pp_count", 64'(count), 64'd2);
      lit("pp_pc4",   64'(PC4_D), 64'h4000 + 64'(4 * (k + 1)));
    end
    f_valid = 0;
    tick();
    tick();
    d_ready = 0;
    lit("pp_drained", 64'(count), 64'd0);

    // Flush mid-operation
    for (int n = 0; n < 3; n++) begin
      set_in(1, 32'h0000_0300 + 32'(n), 32'h0000_5000 + 32'(4 * n));
      tick();
    end
    lit("fl_pre_count", 64'(count), 64'd3);
    flush = 1; set_in(1, 32'h0000_03ff, 32'h0000_50ff);
    tick();
    flush = 0; f_valid = 0;
    lit("fl_count",  64'(count),   64'd0);
    lit("fl_dvalid", 64'(d_valid), 64'd0);
    lit("fl_ir",     64'(IR_D),    64'd0);
    set_in(1, 32'h2409_0007, 32'h0000_6004);
    #1;
    lit("fl_no_fallthru", 64'(d_valid), 64'd0);
    tick();
    f_valid = 0;
    lit("fl_next_ir", 64'(IR_D), 64'h2409_0007);
    d_ready = 1;
    tick();
    d_ready = 0;

    // Flush together with reset
    set_in(1, 32'h0000_0400, 32'h0000_7004);
    tick();
    reset = 1; flush = 1;
    tick();
    reset = 0; flush = 0; f_valid = 0;
    lit("rstfl_count", 64'(count), 64'd0);

    // Sideband fields
    set_in(1, 32'h0000_0500, 32'h0000_8004);
    f_exc = 5'd4; f_bd = 1;
    tick();
    f_valid = 0; f_exc = 0; f_bd = 0;
    lit("sb_exc", 64'(EXC_D), 64'd4);
    lit("sb_bd",  64'(BD_D),  64'd1);
    d_ready = 1;
    tick();
    d_ready = 0;
    lit("sb_exc_clr", 64'(EXC_D), 64'd0);
    lit("sb_bd_clr",  64'(BD_D),  64'd0);

    tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
